// File: rtl/mips_pkg.sv
// Shared types for the MEM stage: handshake FSM states and the EX/MEM, MEM/WB payloads.
package mips_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] store_data;
    logic [WORD_W-1:0] branch_target;
    logic [REG_W-1:0]  write_register;
    logic              zero;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
  } ex_mem_t;

  typedef struct packed {
    logic [WORD_W-1:0] read_data;
    logic [WORD_W-1:0] alu_result;
    logic [REG_W-1:0]  write_register;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_wb_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  import mips_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_handshake_fsm.sv
// Data-memory handshake: request/stall generation, timeout abort and sticky bus error.
module mem_handshake_fsm
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic misaligned,
  input  logic illegal,
  input  logic mem_ack,
  output logic mem_req,
  output logic stall,
  output logic complete,
  output logic abort,
  output logic bus_error
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             bus_error_next;
  logic             aligned_op;

  assign aligned_op = mem_op & ~misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bus_error <= bus_error_next;
    end
  end

  // Counter tracks unacknowledged request cycles; the IDLE issue cycle counts as the first.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bus_error_next = bus_error | misaligned | illegal;
    case (state)
      IDLE: begin
        if (aligned_op && !mem_ack) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_next = IDLE;
        end else if (cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next     = ABORT;
          bus_error_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        mem_req  = aligned_op;
        stall    = aligned_op & ~mem_ack;
        complete = aligned_op & mem_ack;
      end
      WAIT: begin
        mem_req  = 1'b1;
        stall    = ~mem_ack;
        complete = mem_ack;
      end
      ABORT:   abort = 1'b1;
      default: abort = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, branch resolution, data-memory access, MEM/WB register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    ALU_result,
  input  logic [WORD_W-1:0]    read_data_2_id_ex,
  input  logic [REG_W-1:0]     write_register,
  input  logic [WORD_W-1:0]    branch_or_not_address,
  input  logic                 zero,
  input  logic                 ctrl_memRead,
  input  logic                 ctrl_memWrite,
  input  logic                 ctrl_regWrite,
  input  logic                 ctrl_memToReg,
  input  logic                 ctrl_branch,
  mem_access_stage_if.master   mem,
  output logic                 stall_pipeline,
  output logic                 pcSrc,
  output logic [WORD_W-1:0]    branch_target,
  output logic [WORD_W-1:0]    read_data_mem_wb,
  output logic [WORD_W-1:0]    ALU_result_mem_wb,
  output logic [REG_W-1:0]     write_register_mem_wb,
  output logic                 ctrl_regWrite_mem_wb,
  output logic                 ctrl_memToReg_mem_wb,
  output logic                 bus_error
);
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  logic    mem_op, misaligned, illegal, is_store;
  logic    mem_req, mem_complete, mem_abort, wb_bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem <= '0;
    end else if (!stall_pipeline) begin
      ex_mem <= '{alu_result:     ALU_result,
                  store_data:     read_data_2_id_ex,
                  branch_target:  branch_or_not_address,
                  write_register: write_register,
                  zero:           zero,
                  mem_read:       ctrl_memRead,
                  mem_write:      ctrl_memWrite,
                  reg_write:      ctrl_regWrite,
                  mem_to_reg:     ctrl_memToReg,
                  branch:         ctrl_branch};
    end
  end

  // Read+write together is illegal and falls back to a read.
  assign mem_op     = ex_mem.mem_read | ex_mem.mem_write;
  assign illegal    = ex_mem.mem_read & ex_mem.mem_write;
  assign is_store   = ex_mem.mem_write & ~ex_mem.mem_read;
  assign misaligned = mem_op & (ex_mem.alu_result[1:0] != 2'b00);

  mem_handshake_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_op     (mem_op),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_ack    (mem.mem_ack),
    .mem_req    (mem_req),
    .stall      (stall_pipeline),
    .complete   (mem_complete),
    .abort      (mem_abort),
    .bus_error  (bus_error)
  );

  assign mem.mem_req   = mem_req;
  assign mem.mem_addr  = ADDR_W'(ex_mem.alu_result);
  assign mem.mem_wdata = ex_mem.store_data;
  assign mem.mem_we    = is_store;

  // Stall gating makes a branch fire exactly once.
  assign pcSrc         = ex_mem.branch & ex_mem.zero & ~stall_pipeline;
  assign branch_target = ex_mem.branch_target;

  assign wb_bubble = stall_pipeline | mem_abort | misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb <= '0;
    end else begin
      mem_wb.alu_result     <= ex_mem.alu_result;
      mem_wb.write_register <= ex_mem.write_register;
      mem_wb.reg_write      <= ~wb_bubble & ex_mem.reg_write & ~is_store &
                               (ex_mem.write_register != '0);
      mem_wb.mem_to_reg     <= ~wb_bubble & ex_mem.mem_to_reg;
      if (mem_complete && ex_mem.mem_read) begin
        mem_wb.read_data <= mem.mem_rdata;
      end
    end
  end

  assign read_data_mem_wb      = mem_wb.read_data;
  assign ALU_result_mem_wb     = mem_wb.alu_result;
  assign write_register_mem_wb = mem_wb.write_register;
  assign ctrl_regWrite_mem_wb  = mem_wb.reg_write;
  assign ctrl_memToReg_mem_wb  = mem_wb.mem_to_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: single-instruction vector table plus multi-cycle sequences.
module tb_mem_access_stage;
  logic        clk;
  logic        reset;
  logic [31:0] ALU_result, read_data_2_id_ex, branch_or_not_address;
  logic [4:0]  write_register;
  logic        zero, ctrl_memRead, ctrl_memWrite, ctrl_regWrite, ctrl_memToReg, ctrl_branch;
  logic        stall_pipeline, pcSrc, bus_error;
  logic [31:0] branch_target, read_data_mem_wb, ALU_result_mem_wb;
  logic [4:0]  write_register_mem_wb;
  logic        ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if #(.ADDR_W(32)) mbus ();

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ALU_result            (ALU_result),
    .read_data_2_id_ex     (read_data_2_id_ex),
    .write_register        (write_register),
    .branch_or_not_address (branch_or_not_address),
    .zero                  (zero),
    .ctrl_memRead          (ctrl_memRead),
    .ctrl_memWrite         (ctrl_memWrite),
    .ctrl_regWrite         (ctrl_regWrite),
    .ctrl_memToReg         (ctrl_memToReg),
    .ctrl_branch           (ctrl_branch),
    .mem                   (mbus),
    .stall_pipeline        (stall_pipeline),
    .pcSrc                 (pcSrc),
    .branch_target         (branch_target),
    .read_data_mem_wb      (read_data_mem_wb),
    .ALU_result_mem_wb     (ALU_result_mem_wb),
    .write_register_mem_wb (write_register_mem_wb),
    .ctrl_regWrite_mem_wb  (ctrl_regWrite_mem_wb),
    .ctrl_memToReg_mem_wb  (ctrl_memToReg_mem_wb),
    .bus_error             (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wdata, target;
    logic [4:0]  wr;
    logic        zero, rd, we, regw, m2r, br, ack;
    logic [31:0] rdata;
    logic        e_pc, e_req, e_we, e_stall, e_regw, e_m2r;
    logic [31:0] e_rdwb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] target,
                        input logic [4:0] wr, input logic z, input logic rd, input logic we,
                        input logic regw, input logic m2r, input logic br);
    ALU_result = alu; read_data_2_id_ex = wdata; branch_or_not_address = target;
    write_register = wr; zero = z; ctrl_memRead = rd; ctrl_memWrite = we;
    ctrl_regWrite = regw; ctrl_memToReg = m2r; ctrl_branch = br;
  endtask

  task automatic clear_ex();
    set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //           alu        wdata      target    wr  z  rd we rw m2r br ack rdata         pc req we st rw m2r rdwb
    vecs[0] = '{32'h10,   32'hAAAA,  32'h0,    8, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0};
    vecs[1] = '{32'h0,    32'h0,     32'h40,   0, 1, 0, 0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0, 32'h0};
    vecs[2] = '{32'h4,    32'h0,     32'h80,   0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0};
    vecs[3] = '{32'h204,  32'h1234,  32'h0,    5, 0, 0, 1, 1, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h0};
    vecs[4] = '{32'h300,  32'h0,     32'h0,    9, 0, 1, 0, 1, 1, 0, 1, 32'hCAFEF00D, 0, 1, 0, 0, 1, 1, 32'hCAFEF00D};
    vecs[5] = '{32'h77,   32'h0,     32'h0,    0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'hCAFEF00D};
    vecs[6] = '{32'h55,   32'h0,     32'h0,    3, 0, 0, 0, 1, 0, 0, 1, 32'h11111111, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D};

    clear_ex();
    mbus.mem_ack = 1'b0;
    mbus.mem_rdata = 32'h0;
    reset = 1'b1;
    tick();
    mid();
    chk("rst_req", 32'(mbus.mem_req), 32'h0);
    chk("rst_stall", 32'(stall_pipeline), 32'h0);
    chk("rst_pcsrc", 32'(pcSrc), 32'h0);
    chk("rst_alu_wb", ALU_result_mem_wb, 32'h0);
    chk("rst_rd_wb", read_data_mem_wb, 32'h0);
    chk("rst_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    tick();
    reset = 1'b0;

    // Single-instruction vectors, one instruction followed by a bubble.
    for (int i = 0; i < 7; i++) begin
      tick();
      set_ex(vecs[i].alu, vecs[i].wdata, vecs[i].target, vecs[i].wr, vecs[i].zero,
             vecs[i].rd, vecs[i].we, vecs[i].regw, vecs[i].m2r, vecs[i].br);
      tick();
      clear_ex();
      mbus.mem_ack = vecs[i].ack;
      mbus.mem_rdata = vecs[i].rdata;
      mid();
      chk($sformatf("v%0d_pcsrc", i), 32'(pcSrc), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_target", i), branch_target, vecs[i].target);
      chk($sformatf("v%0d_req", i), 32'(mbus.mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(mbus.mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), mbus.mem_addr, vecs[i].alu);
      chk($sformatf("v%0d_stall", i), 32'(stall_pipeline), 32'(vecs[i].e_stall));
      if (vecs[i].e_req) chk($sformatf("v%0d_wdata", i), mbus.mem_wdata, vecs[i].wdata);
      tick();
      mbus.mem_ack = 1'b0;
      mid();
      chk($sformatf("v%0d_pcsrc_once", i), 32'(pcSrc), 32'h0);
      chk($sformatf("v%0d_alu_wb", i), ALU_result_mem_wb, vecs[i].alu);
      chk($sformatf("v%0d_wr_wb", i), 32'(write_register_mem_wb), 32'(vecs[i].wr));
      chk($sformatf("v%0d_regw_wb", i), 32'(ctrl_regWrite_mem_wb), 32'(vecs[i].e_regw));
      chk($sformatf("v%0d_m2r_wb", i), 32'(ctrl_memToReg_mem_wb), 32'(vecs[i].e_m2r));
      chk($sformatf("v%0d_rd_wb", i), read_data_mem_wb, vecs[i].e_rdwb);
    end

    // Load with ack on the third request cycle; next instruction held upstream.
    tick();
    set_ex(32'h100, 32'h0, 32'h0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_ex(32'h20, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc > 0) tick();
      if (cyc == 2) begin
        mbus.mem_ack = 1'b1;
        mbus.mem_rdata = 32'hDEADBEEF;
      end
      mid();
      chk($sformatf("ld3_req_c%0d", cyc), 32'(mbus.mem_req), 32'h1);
      chk($sformatf("ld3_addr_c%0d", cyc), mbus.mem_addr, 32'h100);
      chk($sformatf("ld3_stall_c%0d", cyc), 32'(stall_pipeline), (cyc < 2) ? 32'h1 : 32'h0);
      if (cyc > 0) chk($sformatf("ld3_bubble_c%0d", cyc), 32'(ctrl_regWrite_mem_wb), 32'h0);
    end
    tick();
    mbus.mem_ack = 1'b0;
    mid();
    chk("ld3_rd_wb", read_data_mem_wb, 32'hDEADBEEF);
    chk("ld3_m2r_wb", 32'(ctrl_memToReg_mem_wb), 32'h1);
    chk("ld3_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h1);
    chk("ld3_wr_wb", 32'(write_register_mem_wb), 32'd10);
    chk("ld3_req_after", 32'(mbus.mem_req), 32'h0);
    tick();
    clear_ex();
    mid();
    chk("ld3_next_alu_wb", ALU_result_mem_wb, 32'h20);
    chk("ld3_next_wr_wb", 32'(write_register_mem_wb), 32'd11);

    // Misaligned load becomes a bubble and sets bus_error.
    tick();
    set_ex(32'h102, 32'h0, 32'h0, 5'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    clear_ex();
    mid();
    chk("mis_req", 32'(mbus.mem_req), 32'h0);
    chk("mis_stall", 32'(stall_pipeline), 32'h0);
    chk("mis_bus_error_before", 32'(bus_error), 32'h0);
    tick();
    mid();
    chk("mis_bus_error", 32'(bus_error), 32'h1);
    chk("mis_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h0);
    chk("mis_m2r_wb", 32'(ctrl_memToReg_mem_wb), 32'h0);
    do_reset();
    mid();
    chk("rst_clears_bus_error", 32'(bus_error), 32'h0);

    // Load never acknowledged: timeout after 4 request cycles.
    tick();
    set_ex(32'h180, 32'h0, 32'h0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_ex(32'h44, 32'h0, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (!stall_pipeline) break;
      if (n == 3) chk("to_bus_error_pre", 32'(bus_error), 32'h0);
      n++;
      tick();
    end
    chk("to_stall_cycles", 32'(n), 32'd4);
    chk("to_abort_req", 32'(mbus.mem_req), 32'h0);
    chk("to_bus_error", 32'(bus_error), 32'h1);
    chk("to_abort_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h0);
    tick();
    mid();
    chk("to_bubble_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h0);
    chk("to_resume_stall", 32'(stall_pipeline), 32'h0);
    tick();
    clear_ex();
    mid();
    chk("to_resume_alu_wb", ALU_result_mem_wb, 32'h44);
    chk("to_resume_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h1);

    // Reset asserted while waiting for ack.
    tick();
    set_ex(32'h200, 32'h0, 32'h0, 5'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    mid();
    chk("rw_req", 32'(mbus.mem_req), 32'h1);
    tick();
    mid();
    chk("rw_wait_stall", 32'(stall_pipeline), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_req_drop", 32'(mbus.mem_req), 32'h0);
    chk("rw_stall_drop", 32'(stall_pipeline), 32'h0);
    chk("rw_alu_wb", ALU_result_mem_wb, 32'h0);
    chk("rw_wr_wb", 32'(write_register_mem_wb), 32'h0);
    chk("rw_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h0);
    chk("rw_m2r_wb", 32'(ctrl_memToReg_mem_wb), 32'h0);
    chk("rw_rd_wb", read_data_mem_wb, 32'h0);
    tick();
    reset = 1'b0;
    set_ex(32'h99, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_ex();
    tick();
    mid();
    chk("rw_after_alu_wb", ALU_result_mem_wb, 32'h99);
    chk("rw_after_wr_wb", 32'(write_register_mem_wb), 32'd4);
    chk("rw_after_regw_wb", 32'(ctrl_regWrite_mem_wb), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
